lcd_timing_gen: RTL and testbench

Free-running LCD raster timing generator for the LVDS panel path. It produces the `h_valid`/`v_valid` window consumed by the SDRAM-to-RGB line buffer, plus composite `de`, `hsync`/`vsync`, a frame-start pulse and a one-line-ahead line-request pulse for buffer prefetch. It runs entirely in the LVDS `tx_sclk` domain and sits directly upstream of the pixel buffer / LVDS packing stage. An optional built-in colour-bar source drives the panel without DDR data.

---
 rtl/lcd_timing_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
//
// Free-running LCD raster timing generator in the LVDS tx_sclk domain. Produces the
// h_valid/v_valid window for the line buffer, composite de, active-high hsync/vsync,
// a frame_start pulse on pixel (0,0) and a line_req pulse one line ahead so the buffer
// can prefetch the next active line.
//
// Ports
//   tx_sclk         in   pixel clock
//   rstn_final_tmp  in   asynchronous active-low reset
//   enable          in   run request; only sampled at the last pixel of a frame while running
//   h_valid/v_valid out  horizontal / vertical active region
//   de              out  h_valid & v_valid
//   hsync/vsync     out  active-high syncs
//   frame_start     out  one-cycle pulse at x=0, y=0
//   line_req        out  one-cycle pulse asking for the next active line
//   x_cnt/y_cnt     out  raster position
//   pixel_r/g/b     out  colour-bar pattern pixel
//
// Configuration
//   LCD_TIMING_PATTERN_EN  when defined, pixel_r/g/b carry 8 vertical colour bars
//                          (white, yellow, cyan, green, magenta, red, blue, black) gated
//                          by de; otherwise they are tied to 0.
//
// All outputs are registered from the next-state position so every output in a given
// cycle describes the same (x_cnt, y_cnt).

module lcd_timing_gen #(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 136,
   parameter int unsigned H_BP     = 160,
   parameter int unsigned V_ACTIVE = 600,
   parameter int unsigned V_FP     = 3,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 29
) (
   input  logic        tx_sclk,
   input  logic        rstn_final_tmp,
   input  logic        enable,
   output logic        h_valid,
   output logic        v_valid,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start,
   output logic        line_req,
   output logic [11:0] x_cnt,
   output logic [11:0] y_cnt,
   output logic [7:0]  pixel_r,
   output logic [7:0]  pixel_g,
   output logic [7:0]  pixel_b
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] XLast     = 12'(H_TOTAL - 1);
   localparam logic [11:0] YLast     = 12'(V_TOTAL - 1);
   localparam logic [11:0] XActive   = 12'(H_ACTIVE);
   localparam logic [11:0] YActive   = 12'(V_ACTIVE);
   localparam logic [11:0] YActLast  = 12'(V_ACTIVE - 1);
   localparam logic [11:0] HSyncBeg  = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HSyncEnd  = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VSyncBeg  = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VSyncEnd  = 12'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

   state_e      st_q, st_d;
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic        run_d;

   logic h_valid_q, h_valid_d;
   logic v_valid_q, v_valid_d;
   logic de_q, de_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic frame_start_q, frame_start_d;
   logic line_req_q, line_req_d;

   // Next raster position and state.
   always_comb begin
      st_d = st_q;
      x_d  = x_q;
      y_d  = y_q;
      unique case (st_q)
         StIdle: begin
            if (enable) begin
               st_d = StRun;
            end
         end
         StRun: begin
            if (x_q == XLast) begin
               x_d = '0;
               if (y_q == YLast) begin
                  y_d = '0;
                  // Frame boundary is the only point where a stop request is honoured.
                  if (!enable) begin
                     st_d = StIdle;
                  end
               end else begin
                  y_d = y_q + 12'd1;
               end
            end else begin
               x_d = x_q + 12'd1;
            end
         end
      endcase
      // IDLE always holds (and RUN always enters at) the origin.
      if (st_d == StIdle || st_q == StIdle) begin
         x_d = '0;
         y_d = '0;
      end
   end

   // Outputs are decoded from the next position so they line up with x_cnt/y_cnt.
   always_comb begin
      run_d         = (st_d == StRun);
      h_valid_d     = run_d & (x_d < XActive);
      v_valid_d     = run_d & (y_d < YActive);
      de_d          = h_valid_d & v_valid_d;
      hsync_d       = run_d & (x_d >= HSyncBeg) & (x_d < HSyncEnd);
      vsync_d       = run_d & (y_d >= VSyncBeg) & (y_d < VSyncEnd);
      frame_start_d = run_d & (x_d == 12'd0) & (y_d == 12'd0);
      // Request the next line at the end of the active part of any line whose
      // successor is active; the last frame line requests line 0 of the next frame.
      // Entering RUN also requests line 0, since no previous frame did.
      line_req_d    = run_d & ((st_q == StIdle) |
                               ((x_d == XActive) & ((y_d < YActLast) | (y_d == YLast))));
   end

   always_ff @(posedge tx_sclk or negedge rstn_final_tmp) begin
      if (!rstn_final_tmp) begin
         st_q          <= StIdle;
         x_q           <= '0;
         y_q           <= '0;
         h_valid_q     <= 1'b0;
         v_valid_q     <= 1'b0;
         de_q          <= 1'b0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         frame_start_q <= 1'b0;
         line_req_q    <= 1'b0;
      end else begin
         st_q          <= st_d;
         x_q           <= x_d;
         y_q           <= y_d;
         h_valid_q     <= h_valid_d;
         v_valid_q     <= v_valid_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
         line_req_q    <= line_req_d;
      end
   end

   assign h_valid     = h_valid_q;
   assign v_valid     = v_valid_q;
   assign de          = de_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = frame_start_q;
   assign line_req    = line_req_q;
   assign x_cnt       = x_q;
   assign y_cnt       = y_q;

`ifdef LCD_TIMING_PATTERN_EN
   localparam logic [11:0] BarLast = 12'(H_ACTIVE / 8 - 1);

   // bar_pos/bar_idx track the pixel at x_cnt: position within the bar and bar number.
   logic [11:0] bar_pos_q, bar_pos_d;
   logic [2:0]  bar_idx_q, bar_idx_d;
   logic [7:0]  pix_r_q, pix_r_d;
   logic [7:0]  pix_g_q, pix_g_d;
   logic [7:0]  pix_b_q, pix_b_d;

   always_comb begin
      bar_pos_d = bar_pos_q + 12'd1;
      bar_idx_d = bar_idx_q;
      if (x_d == 12'd0) begin
         bar_pos_d = '0;
         bar_idx_d = '0;
      end else if (bar_pos_q == BarLast) begin
         bar_pos_d = '0;
         bar_idx_d = bar_idx_q + 3'd1;
      end
      // Bar index bits map straight to the missing colour components:
      // red absent on idx 2,3,6,7; green absent on 4..7; blue absent on odd idx.
      pix_r_d = {8{de_d & ~bar_idx_d[1]}};
      pix_g_d = {8{de_d & ~bar_idx_d[2]}};
      pix_b_d = {8{de_d & ~bar_idx_d[0]}};
   end

   always_ff @(posedge tx_sclk or negedge rstn_final_tmp) begin
      if (!rstn_final_tmp) begin
         bar_pos_q <= '0;
         bar_idx_q <= '0;
         pix_r_q   <= '0;
         pix_g_q   <= '0;
         pix_b_q   <= '0;
      end else begin
         bar_pos_q <= bar_pos_d;
         bar_idx_q <= bar_idx_d;
         pix_r_q   <= pix_r_d;
         pix_g_q   <= pix_g_d;
         pix_b_q   <= pix_b_d;
      end
   end

   assign pixel_r = pix_r_q;
   assign pixel_g = pix_g_q;
   assign pixel_b = pix_b_q;
`else
   assign pixel_r = '0;
   assign pixel_g = '0;
   assign pixel_b = '0;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen with a small raster (14 x 7).
// The reference model tracks a single pixel index within the frame and derives
// every output from it arithmetically.

module tb_lcd_timing_gen;

   localparam int HA = 8;
   localparam int HF = 2;
   localparam int HS = 2;
   localparam int HB = 2;
   localparam int VA = 4;
   localparam int VF = 1;
   localparam int VS = 1;
   localparam int VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        tx_sclk = 1'b0;
   logic        rstn_final_tmp = 1'b0;
   logic        enable = 1'b0;
   logic        h_valid, v_valid, de, hsync, vsync, frame_start, line_req;
   logic [11:0] x_cnt, y_cnt;
   logic [7:0]  pixel_r, pixel_g, pixel_b;

   lcd_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) u_dut (
      .tx_sclk       (tx_sclk),
      .rstn_final_tmp(rstn_final_tmp),
      .enable        (enable),
      .h_valid       (h_valid),
      .v_valid       (v_valid),
      .de            (de),
      .hsync         (hsync),
      .vsync         (vsync),
      .frame_start   (frame_start),
      .line_req      (line_req),
      .x_cnt         (x_cnt),
      .y_cnt         (y_cnt),
      .pixel_r       (pixel_r),
      .pixel_g       (pixel_g),
      .pixel_b       (pixel_b)
   );

   always #5 tx_sclk = ~tx_sclk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: running flag, pixel index in frame, and "just started" flag.
   bit m_run   = 1'b0;
   int m_pos   = 0;
   bit m_first = 1'b0;

`ifdef LCD_TIMING_PATTERN_EN
   function automatic logic [23:0] bar_rgb(input int idx);
      case (idx)
         0:       return 24'hFFFFFF; // white
         1:       return 24'hFFFF00; // yellow
         2:       return 24'h00FFFF; // cyan
         3:       return 24'h00FF00; // green
         4:       return 24'hFF00FF; // magenta
         5:       return 24'hFF0000; // red
         6:       return 24'h0000FF; // blue
         default: return 24'h000000; // black
      endcase
   endfunction
`endif

   function automatic logic [54:0] model_vec();
      int   x, y;
      logic hv, vv, e_de, hs, vs, fs, lr;
      logic [23:0] rgb;
      if (!m_run) return '0;
      x    = m_pos % HT;
      y    = m_pos / HT;
      hv   = (x < HA);
      vv   = (y < VA);
      e_de = hv && vv;
      hs   = (x >= HA + HF) && (x < HA + HF + HS);
      vs   = (y >= VA + VF) && (y < VA + VF + VS);
      fs   = (m_pos == 0);
      lr   = m_first || ((x == HA) && ((y < VA - 1) || (y == VT - 1)));
      rgb  = '0;
`ifdef LCD_TIMING_PATTERN_EN
      if (e_de) rgb = bar_rgb(x / (HA / 8));
`endif
      return {hv, vv, e_de, hs, vs, fs, lr, 12'(x), 12'(y), rgb};
   endfunction

   function automatic logic [54:0] dut_vec();
      return {h_valid, v_valid, de, hsync, vsync, frame_start, line_req,
              x_cnt, y_cnt, pixel_r, pixel_g, pixel_b};
   endfunction

   task automatic model_edge();
      if (!rstn_final_tmp) begin
         m_run   = 1'b0;
         m_first = 1'b0;
      end else if (!m_run) begin
         m_first = enable;
         if (enable) begin
            m_run = 1'b1;
            m_pos = 0;
         end
      end else begin
         m_first = 1'b0;
         if (m_pos == FT - 1) begin
            if (enable) m_pos = 0;
            else        m_run = 1'b0;
         end else begin
            m_pos++;
         end
      end
   endtask

   task automatic step();
      @(posedge tx_sclk);
      model_edge();
      #1;
      check_val("outs", dut_vec(), model_vec());
   endtask

   task automatic async_reset();
      rstn_final_tmp = 1'b0;
      #1;
      m_run   = 1'b0;
      m_first = 1'b0;
      check_val("rst_async", dut_vec(), model_vec());
   endtask

   int de_cnt, lr_cnt, fs_cnt, hv_cnt, guard, last_x, last_y;

   initial begin
      // Reset held with enable high: everything stays 0.
      enable = 1'b1;
      #3;
      check_val("rst_outs", dut_vec(), 55'd0);
      for (int i = 0; i < 3; i++) step();
      rstn_final_tmp = 1'b1;

      // First frame: frame_start and line_req on the very first cycle.
      de_cnt = 0; lr_cnt = 0; fs_cnt = 0; hv_cnt = 0;
      for (int i = 0; i < FT; i++) begin
         step();
         if (i == 0) begin
            check_val("fs_first", {63'd0, frame_start}, 64'd1);
            check_val("lr_first", {63'd0, line_req}, 64'd1);
         end
         if (i < HT) hv_cnt += int'(h_valid);
         de_cnt += int'(de);
         lr_cnt += int'(line_req);
         fs_cnt += int'(frame_start);
      end
      check_val("hv_per_line", hv_cnt, 8);
      check_val("de_per_frame", de_cnt, 32);
      check_val("lr_frame1", lr_cnt, 5);
      check_val("fs_frame1", fs_cnt, 1);

      // Second frame: frame_start period and four line requests.
      lr_cnt = 0;
      for (int i = 0; i < FT; i++) begin
         step();
         if (i == 0) check_val("fs_period", {63'd0, frame_start}, 64'd1);
         lr_cnt += int'(line_req);
      end
      check_val("lr_frame2", lr_cnt, 4);

      // Drop enable mid-frame: frame completes, then idle.
      guard = 0;
      while (m_pos / HT != 2 && guard < 2 * FT) begin
         step();
         guard++;
      end
      check_val("reach_y2", y_cnt, 2);
      enable = 1'b0;
      last_x = -1; last_y = -1; guard = 0;
      while (m_run && guard < 2 * FT) begin
         last_x = int'(x_cnt);
         last_y = int'(y_cnt);
         step();
         guard++;
      end
      check_val("last_x", last_x, HT - 1);
      check_val("last_y", last_y, VT - 1);
      for (int i = 0; i < 4; i++) step();
      enable = 1'b1;
      step();
      check_val("fs_reenable", {63'd0, frame_start}, 64'd1);

      // Asynchronous reset at x=5, y=1.
      guard = 0;
      while (m_pos != HT + 5 && guard < 2 * FT) begin
         step();
         guard++;
      end
      check_val("at_x5", x_cnt, 5);
      async_reset();
      check_val("rst_x", x_cnt, 0);
      for (int i = 0; i < 2; i++) step();
      rstn_final_tmp = 1'b1;
      step();
      check_val("restart_xy", {x_cnt, y_cnt}, 24'd0);
      check_val("restart_fs", {63'd0, frame_start}, 64'd1);

      // Randomized enable and occasional asynchronous resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) enable = ($urandom_range(0, 2) != 0);
         if (rstn_final_tmp && $urandom_range(0, 399) == 0) begin
            async_reset();
         end else if (!rstn_final_tmp && $urandom_range(0, 2) == 0) begin
            rstn_final_tmp = 1'b1;
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
